// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding,
// op-class helpers and default latencies.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MADD  = 4'd5,
        MD_MADDU = 4'd6,
        MD_MSUB  = 4'd7,
        MD_MSUBU = 4'd8,
        MD_MTHI  = 4'd9,
        MD_MTLO  = 4'd10
    } md_op_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic is_long_op(input md_op_e op);
        unique case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_op(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational result datapath: next {hi,lo} from latched operands,
// op and current hi/lo, including div-by-zero and INT_MIN/-1 rules.
module md_core
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]           acc;
    logic [W2-1:0]           prod_s;
    logic [W2-1:0]           prod_u;
    logic [W2-1:0]           res;
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] q_s;
    logic signed [WIDTH-1:0] r_s;
    logic [WIDTH-1:0]        q_u;
    logic [WIDTH-1:0]        r_u;
    logic                    div_zero;
    logic                    div_ovf;

    always_comb begin
        acc      = {hi_in, lo_in};
        // Sign-extended operands give the exact signed product mod 2^W2
        prod_u   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        prod_s   = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        sa       = $signed(a);
        sb       = $signed(b);
        div_zero = (b == '0);
        div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
        q_s      = '0;
        r_s      = '0;
        q_u      = '0;
        r_u      = '0;
        if (!div_zero && !div_ovf) begin
            q_s = sa / sb;
            r_s = sa % sb;
        end
        if (!div_zero) begin
            q_u = a / b;
            r_u = a % b;
        end
        res = acc;
        unique case (op)
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_MADD:  res = acc + prod_s;
            MD_MADDU: res = acc + prod_u;
            MD_MSUB:  res = acc - prod_s;
            MD_MSUBU: res = acc - prod_u;
            MD_DIV: begin
                if (div_zero)     res = acc;
                else if (div_ovf) res = {{WIDTH{1'b0}}, a};
                else              res = {r_s, q_s};
            end
            MD_DIVU: begin
                if (div_zero) res = acc;
                else          res = {r_u, q_u};
            end
            default: res = acc;
        endcase
        hi_out = res[W2-1:WIDTH];
        lo_out = res[WIDTH-1:0];
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: HI/LO registers, operand latches and a
// per-class latency counter that drives busy for the hazard unit.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_e           md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    md_op_e           op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic             accept;

    md_core #(.WIDTH(WIDTH)) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_in  (hi_q),
        .lo_in  (lo_q),
        .hi_out (core_hi),
        .lo_out (core_lo)
    );

    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        accept = start && !busy_q;
        if (cnt_q == CW'(1)) begin
            hi_d  = core_hi;
            lo_d  = core_lo;
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else if (accept) begin
            unique case (1'b1)
                is_long_op(md_op): begin
                    op_d  = md_op;
                    a_d   = src_a;
                    b_d   = src_b;
                    cnt_d = is_div_op(md_op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
                end
                (md_op == MD_MTHI): hi_d = src_a;
                (md_op == MD_MTLO): lo_d = src_a;
                default: ;
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            op_q   <= MD_NONE;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops push expected hi/lo and
// busy length; a negedge monitor pops on each observable result.
module tb_md_unit;
    import md_pkg::*;

    typedef struct {
        string       name;
        int          lat;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    md_op_e      md_op = MD_NONE;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic obs = 1'b0;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   viol = 0;

    md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic pop_check(input bit from_busy, input int run);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual hi=%h lo=%h required none",
                     hi, lo);
            return;
        end
        e = sb.pop_front();
        if (from_busy) chk({e.name, "_lat"}, 32'(run), 32'(e.lat));
        else           chk({e.name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
    endtask

    // monitor
    initial begin
        int run = 0;
        bit prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                run++;
            end else begin
                if (prev)     pop_check(1'b1, run);
                else if (obs) pop_check(1'b0, 0);
                run = 0;
            end
            prev = busy;
        end
    end

    // flags starts the hazard unit should never let through
    initial begin
        forever begin
            @(posedge clk);
            if (start && busy) begin
                viol++;
                $display("note: start while busy at %0t", $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            if (!busy) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL wait_idle actual=busy required=idle");
    endtask

    task automatic probe(input string nm, input logic [31:0] eh,
                         input logic [31:0] el);
        sb.push_back('{nm, 0, eh, el});
        obs = 1'b1;
        step();
        obs = 1'b0;
    endtask

    function automatic int lat_of(input md_op_e op);
        if (op == MD_DIV || op == MD_DIVU) return 10;
        if (op == MD_MULT || op == MD_MULTU || op == MD_MADD ||
            op == MD_MADDU || op == MD_MSUB || op == MD_MSUBU) return 5;
        return 0;
    endfunction

    task automatic md(input string nm, input md_op_e op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el);
        int l;
        l = lat_of(op);
        sb.push_back('{nm, l, eh, el});
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        if (l == 0) begin
            obs = 1'b1;
            step();
            obs = 1'b0;
        end else begin
            step();
            wait_idle();
        end
    endtask

    initial begin
        step();
        step();
        reset = 1'b0;
        probe("reset", 32'h0, 32'h0);

        md("mult",  MD_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        md("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        md("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md("divu",  MD_DIVU,  32'd7, 32'd2, 32'd1, 32'd3);
        md("div_nd", MD_DIV,  32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        md("mtlo",  MD_MTLO,  32'h1234, 32'h0, 32'd1, 32'h1234);
        md("mthi",  MD_MTHI,  32'h5678, 32'h0, 32'h5678, 32'h1234);
        md("none",  MD_NONE,  32'hDEAD, 32'hBEEF, 32'h5678, 32'h1234);
        md("div0",  MD_DIV,   32'd5, 32'd0, 32'h5678, 32'h1234);
        md("divovf", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        md("mthi0", MD_MTHI,  32'h0, 32'h0, 32'h0, 32'h80000000);
        md("mtlo1", MD_MTLO,  32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF);
        md("maddu", MD_MADDU, 32'd1, 32'd1, 32'd1, 32'd0);
        md("msub",  MD_MSUB,  32'd1, 32'd2, 32'd0, 32'hFFFFFFFE);
        md("madd",  MD_MADD,  32'hFFFFFFFF, 32'd3, 32'd0, 32'hFFFFFFFB);
        md("msubu", MD_MSUBU, 32'd2, 32'd3, 32'd0, 32'hFFFFFFF5);

        // reset three cycles into a multiply
        sb.push_back('{"rst_mid", 3, 32'h0, 32'h0});
        start = 1'b1;
        md_op = MD_MULT;
        src_a = 32'd5;
        src_b = 32'd5;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) step();
        probe("rst_after", 32'h0, 32'h0);

        // illegal start while busy must be ignored
        sb.push_back('{"busy_ign", 5, 32'h0, 32'd12});
        start = 1'b1;
        md_op = MD_MULTU;
        src_a = 32'd3;
        src_b = 32'd4;
        step();
        md_op = MD_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        step();
        start = 1'b0;
        md_op = MD_NONE;
        wait_idle();
        for (int i = 0; i < 12; i++) step();
        probe("busy_after", 32'h0, 32'd12);

        step();
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("viol_flag", 32'(viol), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
